// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory port arbiter.
// Holds the arbiter state encoding, memory map constants and port bundle.
package dmem_arb_pkg;

  localparam int DMEM_WORDS  = 32;
  localparam int WORD_SHIFT  = 2;
  localparam int IO_ADDR_BIT = $clog2(DMEM_WORDS) + WORD_SHIFT;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BURST  = 2'd1,
    ARB_REJECT = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } mem_port_t;

  function automatic logic is_io(input logic [31:0] a);
    return a[IO_ADDR_BIT];
  endfunction

endpackage

// File: rtl/dmem_burst_check.sv
// dmem_burst_check: combinational legality check of a DMA burst request.
// Rejects misaligned bases and bursts that start in or reach I/O space.
module dmem_burst_check
  import dmem_arb_pkg::*;
#(
  parameter int LEN_W = 3
) (
  input  logic [31:0]      base,
  input  logic [LEN_W-1:0] len,
  output logic             reject
);

  logic [31:0] end_addr;
  logic        misaligned;

  always_comb begin
    end_addr   = base + {{(30-LEN_W){1'b0}}, len, 2'b00};
    misaligned = base[1:0] != 2'b00;
    reject     = is_io(end_addr) | is_io(base) | misaligned;
  end

endmodule

// File: rtl/dmem_bus_arbiter.sv
// dmem_bus_arbiter: CPU / burst-DMA arbiter for the shared data-memory port.
// Define DMEM_ARB_FAIR_EN to enable the DMA anti-starvation rule.
module dmem_bus_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int LEN_W        = 3
) (
  input  logic             mem_clk,
  input  logic             clrn,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [31:0]      dma_addr,
  input  logic [LEN_W-1:0] dma_len,
  input  logic [31:0]      dma_wdata,
  output logic             dma_gnt,
  output logic             dma_beat,
  output logic [31:0]      dma_rdata,
  output logic             dma_done,
  output logic             dma_err,
  output logic [31:0]      m_addr,
  output logic [31:0]      m_datain,
  output logic             m_we,
  input  logic [31:0]      m_dataout
);

  arb_state_e       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      base_q, base_d;
  logic             we_q, we_d;

  logic             reject;
  logic             force_burst;
  logic             go_reject;
  logic             start_burst;
  logic             last_beat;
  logic [31:0]      beat_addr;
  mem_port_t        port;

  dmem_burst_check #(
    .LEN_W (LEN_W)
  ) u_check (
    .base   (dma_addr),
    .len    (dma_len),
    .reject (reject)
  );

  assign last_beat = cnt_q == len_q;
  assign beat_addr = base_q + {{(30-LEN_W){1'b0}}, cnt_q, 2'b00};

  assign go_reject = (state_q == ARB_IDLE)
                   & dma_req & reject;

  assign start_burst = (state_q == ARB_IDLE)
                     & dma_req & ~reject
                     & (~cpu_req | force_burst);

`ifdef DMEM_ARB_FAIR_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX =
    STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_burst = starve_q == STARVE_MAX;

  // Counts IDLE cycles where the DMA loses to the CPU.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ARB_IDLE) begin
      if (!dma_req || start_burst || go_reject)
        starve_d = '0;
      else if (cpu_req && !force_burst)
        starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge mem_clk or posedge clrn) begin
    if (clrn) starve_q <= '0;
    else      starve_q <= starve_d;
  end
`else
  logic unused_limit;
  assign unused_limit = STARVE_LIMIT != 0;
  assign force_burst  = 1'b0;
`endif

  always_ff @(posedge mem_clk or posedge clrn) begin
    if (clrn) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    base_d  = base_q;
    we_d    = we_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (go_reject) begin
          state_d = ARB_REJECT;
        end else if (start_burst) begin
          state_d = ARB_BURST;
          base_d  = dma_addr;
          len_d   = dma_len;
          we_d    = dma_we;
          cnt_d   = '0;
        end
      end
      ARB_BURST: begin
        if (last_beat) state_d = ARB_IDLE;
        else           cnt_d   = cnt_q + 1'b1;
      end
      ARB_REJECT: state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Burst owns the port outright; CPU writes cannot leak through.
  always_comb begin
    port.addr = cpu_addr;
    port.data = cpu_wdata;
    port.we   = cpu_req & cpu_we;
    cpu_stall = 1'b0;
    dma_gnt   = 1'b0;
    dma_beat  = 1'b0;
    dma_done  = 1'b0;
    dma_err   = 1'b0;
    dma_rdata = '0;
    unique case (state_q)
      ARB_IDLE: ;
      ARB_BURST: begin
        port.addr = beat_addr;
        port.data = dma_wdata;
        port.we   = we_q;
        cpu_stall = cpu_req;
        dma_beat  = 1'b1;
        dma_gnt   = cnt_q == '0;
        dma_done  = last_beat;
        dma_rdata = m_dataout;
      end
      ARB_REJECT: dma_err = 1'b1;
      default: ;
    endcase
  end

  assign m_addr    = port.addr;
  assign m_datain  = port.data;
  assign m_we      = port.we;
  assign cpu_rdata = m_dataout;

endmodule

// File: doc/dmem_bus_arbiter.md
# dmem_bus_arbiter

Arbiter and sequencer for the shared data-memory/I-O port (32-word data RAM at word addresses 0x00–0x7C, I/O registers at byte addresses with bit 7 set). It sits between the pipeline MEM stage and a burst DMA/loader port. The CPU has single-cycle pass-through priority. The DMA port gets fixed-length word bursts into data RAM only, with an optional anti-starvation rule. It drives the memory-side address, data and write enable and stalls the pipeline while a burst owns the port.

## Interface
- STARVE_LIMIT, default 4: consecutive contended cycles before DMA is forced through. Only used with DMEM_ARB_FAIR_EN.
- LEN_W, default 3: width of the burst-length field. Burst length is dma_len+1 words, so 1..8 at the default.
- mem_clk  in  1  sole clock; all state updates on its rising edge
- clrn  in  1  asynchronous, active-high reset
- cpu_req  in  1  MEM stage has a load/store this cycle
- cpu_we  in  1  store
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid in the same cycle as the request when not stalled
- cpu_stall  out  1  hold the MEM stage; the request is re-presented next cycle
- dma_req  in  1  burst request; held until dma_gnt or dma_err
- dma_we  in  1  burst is a write
- dma_addr  in  32  burst base byte address, word aligned
- dma_len  in  LEN_W  words minus one
- dma_wdata  in  32  current beat write data
- dma_gnt  out  1  one-cycle pulse in the first beat
- dma_beat  out  1  a beat is on the port this cycle; the source advances dma_wdata after each beat
- dma_rdata  out  32  read beat data, valid when dma_beat && !dma_we_q
- dma_done  out  1  pulse on the last beat
- dma_err  out  1  one-cycle pulse when a request is rejected
- m_addr  out  32  to memory/I-O decoder
- m_datain  out  32  write data
- m_we  out  1  write enable
- m_dataout  in  32  read data, valid in the same cycle as m_addr

## Operation
- States:
  - IDLE: the CPU owns the port.
  - BURST: the DMA owns the port.
  - REJECT: one cycle, asserts dma_err.
- IDLE:
  - m_addr, m_datain and cpu_rdata come combinationally from the cpu_* / m_dataout signals.
  - m_we = cpu_req & cpu_we.
  - cpu_stall = 0.
- Rejection: a burst is illegal if the end address base + 4·dma_len has bit 7 set, or base[7] = 1, or base[1:0] ≠ 0. This covers bursts that start in or cross into I/O space.
- IDLE, on the edge:
  - If dma_req is set and the burst is illegal, go to REJECT.
  - Else, if dma_req is set and (!cpu_req or the force condition holds), latch base, len and we into base_q, len_q and we_q, clear beat counter cnt, and go to BURST.
  - Else stay in IDLE.
- BURST:
  - m_addr = base_q + {cnt,2'b00}; m_we = we_q; m_datain = dma_wdata.
  - dma_beat = 1; dma_rdata = m_dataout; dma_gnt = (cnt == 0).
  - cpu_stall = cpu_req. CPU writes are blocked (m_we comes from we_q only).
  - On the edge, if cnt == len_q go to IDLE, else increment cnt.
  - dma_done = (cnt == len_q).
- REJECT: dma_err = 1, then go to IDLE. The memory sees no access for the DMA, and the CPU is served normally in this cycle.
- Bursts are never preempted, so the worst-case CPU stall is len+1 cycles.
- cnt is LEN_W bits and cannot wrap, because it stops at len_q.
- Reset mid-burst: the burst is abandoned, and no dma_done or dma_err is raised.
- Reset values:
  - State IDLE; cnt, base_q, len_q, we_q and the starvation counter all 0.
  - Derived outputs: cpu_stall, dma_gnt, dma_beat, dma_done, dma_err and m_we are 0 unless cpu_req is driven.

## Timing
- CPU access, uncontended: zero added latency; data is returned in the request cycle.
- DMA grant latency: one edge after dma_req is seen in IDLE with the port free. The first beat runs in the following cycle.
- Beats: one per cycle, back to back; the done pulse coincides with the last beat.
- After the last beat, the CPU is served in the very next cycle, with no turnaround.
- If dma_req and cpu_req arrive in the same IDLE cycle, the CPU is served that cycle and the DMA waits, unless forced.
- A new dma_req may be accepted in the IDLE cycle directly after a burst ends.

## Configuration
- DMEM_ARB_FAIR_EN defined:
  - A starvation counter increments on each IDLE cycle with dma_req && cpu_req, saturating at STARVE_LIMIT.
  - It clears on the burst-start edge, on entry to REJECT, or on any IDLE cycle with dma_req = 0.
  - The force condition is counter == STARVE_LIMIT. The CPU is still served in that cycle, then the burst starts.
- Undefined: strict CPU priority. There is no counter, and the force condition is constant 0.

## Structure
- Shared package dmem_arb_pkg holds:
  - the state encoding (IDLE, BURST, REJECT);
  - IO_ADDR_BIT = 7;
  - the DMEM_WORDS = 32 constant.
- One sub-module, dmem_burst_check: combinational legality check of base/len, producing the reject flag.

## Test plan
- CPU store 0x1234_5678 to 0x08, then a CPU load from 0x08: cpu_stall = 0 throughout, m_we pulses once, and cpu_rdata = 0x1234_5678 in the load cycle.
- DMA write burst at base 0x10, len 3, cpu_req = 0: dma_gnt in beat 1; m_addr = 0x10, 0x14, 0x18, 0x1C on consecutive cycles; dma_done on the 0x1C beat. A following DMA read burst returns the same four words on dma_rdata.
- CPU load held for 10 cycles with DMA requesting len 1:
  - without the macro, there is no grant for all 10 cycles;
  - with DMEM_ARB_FAIR_EN, the burst starts after 4 contended cycles and cpu_stall = 1 for exactly 2 cycles.
- DMA base 0x78, len 2 (crosses 0x80): dma_err pulses for one cycle, no dma_beat, m_we never asserted by DMA.
- Assert clrn during beat 2 of a len-7 burst: all outputs return to 0 / pass-through, no dma_done, and the next dma_req is granted normally.
